// File: rtl/fl_checkpoint_ctrl.sv
// Free-list checkpoint controller: keeps one free-list snapshot per in-flight
// branch in a circular stack, folds retiring registers into every live
// snapshot, and emits a one-cycle restore pulse when a branch mispredicts.
`ifndef PHYS_REG_SZ_R10K
`define PHYS_REG_SZ_R10K 64
`endif

module fl_checkpoint_ctrl #(
  parameter int BRANCH_DEPTH = 4,
  parameter int PHYS_REG_SZ  = `PHYS_REG_SZ_R10K,
  parameter int TAG_BITS     = $clog2(BRANCH_DEPTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    branch_dispatch,
  input  logic [PHYS_REG_SZ-1:0]  dispatch_free_list,
  input  logic [PHYS_REG_SZ-1:0]  retire_free_mask,
  input  logic                    resolve_valid,
  input  logic [TAG_BITS-1:0]     resolve_tag,
  input  logic                    resolve_mispredict,
  output logic [TAG_BITS-1:0]     branch_tag,
  output logic                    stack_full,
  output logic [TAG_BITS:0]       num_checkpoints,
  output logic                    restore_flag,
  output logic [PHYS_REG_SZ-1:0]  free_list_restore,
  output logic [BRANCH_DEPTH-1:0] squash_mask
);

  localparam int PTR_BITS = TAG_BITS + 1;

  // Pointers carry a wrap bit in the MSB so full and empty differ.
  logic [PTR_BITS-1:0]     head_reg, head_next;
  logic [PTR_BITS-1:0]     tail_reg, tail_next;
  logic [BRANCH_DEPTH-1:0] valid_reg, valid_next;
  logic [PTR_BITS-1:0]     count;
  logic [TAG_BITS-1:0]     head_idx, tail_idx;
  logic [TAG_BITS-1:0]     m_dist;
  logic                    mispredict, correct, alloc;
  logic [BRANCH_DEPTH-1:0] squash_vec;
  logic [BRANCH_DEPTH-1:0][PHYS_REG_SZ-1:0] snap_all;

  logic                    restore_flag_reg;
  logic [PHYS_REG_SZ-1:0]  free_list_restore_reg;
  logic [BRANCH_DEPTH-1:0] squash_mask_reg;

  assign head_idx = head_reg[TAG_BITS-1:0];
  assign tail_idx = tail_reg[TAG_BITS-1:0];
  assign count    = tail_reg - head_reg;

  assign branch_tag      = tail_idx;
  assign stack_full      = (count == PTR_BITS'(BRANCH_DEPTH));
  assign num_checkpoints = count;

  // A resolve only counts when it names a live slot.
  assign mispredict = resolve_valid &&  resolve_mispredict && valid_reg[resolve_tag];
  assign correct    = resolve_valid && !resolve_mispredict && valid_reg[resolve_tag];
  assign alloc      = branch_dispatch && !stack_full && !mispredict;

  // Age of the resolving slot measured from the oldest entry.
  assign m_dist = resolve_tag - head_idx;

  for (genvar gi = 0; gi < BRANCH_DEPTH; gi++) begin : g_slot
    logic [TAG_BITS-1:0]    slot_dist;
    logic                   slot_alloc;
    logic                   slot_free;
    logic [PHYS_REG_SZ-1:0] snap_reg;

    assign slot_dist  = TAG_BITS'(gi) - head_idx;
    assign slot_alloc = alloc && (tail_idx == TAG_BITS'(gi));
    // Squash covers the mispredicted slot and everything younger up to tail.
    assign squash_vec[gi] = mispredict && ({1'b0, slot_dist} < count) &&
                            (slot_dist >= m_dist);
    assign slot_free  = squash_vec[gi] || (correct && (resolve_tag == TAG_BITS'(gi)));
    assign valid_next[gi] = slot_alloc || (valid_reg[gi] && !slot_free);
    assign snap_all[gi]   = snap_reg;

    // Capture the snapshot on allocation; afterwards keep folding in retirements.
    always_ff @(posedge clock) begin
      if (slot_alloc) begin
        snap_reg <= dispatch_free_list | retire_free_mask;
      end else if (valid_reg[gi] && !slot_free) begin
        snap_reg <= snap_reg | retire_free_mask;
      end
    end
  end

  // Pointer update: a mispredict rewinds tail to the bad slot and blocks
  // allocation and head retirement for that cycle.
  always_comb begin
    head_next = head_reg;
    tail_next = tail_reg;
    if (mispredict) begin
      tail_next = head_reg + {1'b0, m_dist};
      // When the bad slot is the oldest, the rewound tail equals head.
      if (m_dist == '0) begin
        head_next = tail_next;
      end
    end else begin
      if (alloc) begin
        tail_next = tail_reg + PTR_BITS'(1);
      end
      if ((count != '0) && !valid_reg[head_idx]) begin
        head_next = head_reg + PTR_BITS'(1);
      end
    end
  end

  // Stack state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      valid_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      valid_reg <= valid_next;
    end
  end

  // Restore outputs: a single-cycle pulse following each accepted mispredict.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      restore_flag_reg      <= 1'b0;
      free_list_restore_reg <= '0;
      squash_mask_reg       <= '0;
    end else begin
      restore_flag_reg      <= mispredict;
      free_list_restore_reg <= mispredict ? (snap_all[resolve_tag] | retire_free_mask) : '0;
      squash_mask_reg       <= squash_vec;
    end
  end

  assign restore_flag      = restore_flag_reg;
  assign free_list_restore = free_list_restore_reg;
  assign squash_mask       = squash_mask_reg;

endmodule

// File: tb/tb_fl_checkpoint_ctrl.sv
// Bench for fl_checkpoint_ctrl: directed scenarios with literal expectations,
// then random traffic checked every cycle against an unbounded-pointer model.
module tb_fl_checkpoint_ctrl;

  localparam int D = 4;
  localparam int P = 16;
  localparam int T = 2;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           branch_dispatch = 1'b0;
  logic [P-1:0]   dispatch_free_list = '0;
  logic [P-1:0]   retire_free_mask = '0;
  logic           resolve_valid = 1'b0;
  logic [T-1:0]   resolve_tag = '0;
  logic           resolve_mispredict = 1'b0;
  logic [T-1:0]   branch_tag;
  logic           stack_full;
  logic [T:0]     num_checkpoints;
  logic           restore_flag;
  logic [P-1:0]   free_list_restore;
  logic [D-1:0]   squash_mask;

  fl_checkpoint_ctrl #(.BRANCH_DEPTH(D), .PHYS_REG_SZ(P)) dut (
    .clock              (clock),
    .reset              (reset),
    .branch_dispatch    (branch_dispatch),
    .dispatch_free_list (dispatch_free_list),
    .retire_free_mask   (retire_free_mask),
    .resolve_valid      (resolve_valid),
    .resolve_tag        (resolve_tag),
    .resolve_mispredict (resolve_mispredict),
    .branch_tag         (branch_tag),
    .stack_full         (stack_full),
    .num_checkpoints    (num_checkpoints),
    .restore_flag       (restore_flag),
    .free_list_restore  (free_list_restore),
    .squash_mask        (squash_mask)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  // Model: absolute (never-wrapping) head/tail counters plus per-slot contents.
  int           m_head, m_tail;
  bit [D-1:0]   m_valid;
  logic [P-1:0] m_snap [D];
  bit           e_flag;
  logic [P-1:0] e_fl;
  logic [D-1:0] e_sq;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_head = 0;
    m_tail = 0;
    m_valid = '0;
    e_flag = 1'b0;
    e_fl = '0;
    e_sq = '0;
    for (int i = 0; i < D; i++) m_snap[i] = '0;
  endtask

  // Apply one clock edge's worth of rules to the model using the driven inputs.
  task automatic model_step();
    int  cnt;
    int  r;
    int  p;
    bit  adv;
    cnt = m_tail - m_head;
    r = int'(resolve_tag);
    e_flag = 1'b0;
    e_fl = '0;
    e_sq = '0;
    if (resolve_valid && resolve_mispredict && m_valid[r]) begin
      p = m_head + ((r - (m_head % D)) % D + D) % D;
      e_flag = 1'b1;
      e_fl = m_snap[r] | retire_free_mask;
      for (int q = p; q < m_tail; q++) begin
        m_valid[q % D] = 1'b0;
        e_sq[q % D] = 1'b1;
      end
      for (int i = 0; i < D; i++)
        if (m_valid[i]) m_snap[i] = m_snap[i] | retire_free_mask;
      m_tail = p;
    end else begin
      adv = (cnt > 0) && !m_valid[m_head % D];
      if (resolve_valid && m_valid[r]) m_valid[r] = 1'b0;
      for (int i = 0; i < D; i++)
        if (m_valid[i]) m_snap[i] = m_snap[i] | retire_free_mask;
      if (branch_dispatch && cnt < D) begin
        m_valid[m_tail % D] = 1'b1;
        m_snap[m_tail % D] = dispatch_free_list | retire_free_mask;
        m_tail++;
      end
      if (adv) m_head++;
    end
  endtask

  // Compare process: every mid-cycle, outputs against the model.
  always @(negedge clock) begin
    if (check_en) begin
      chk("branch_tag", 64'(branch_tag), 64'(m_tail % D));
      chk("stack_full", 64'(stack_full), 64'((m_tail - m_head) == D));
      chk("num_checkpoints", 64'(num_checkpoints), 64'(m_tail - m_head));
      chk("restore_flag", 64'(restore_flag), 64'(e_flag));
      chk("free_list_restore", 64'(free_list_restore), 64'(e_fl));
      chk("squash_mask", 64'(squash_mask), 64'(e_sq));
    end
  end

  // One clock of stimulus; entered and left just after a falling edge.
  task automatic step(input bit bd, input logic [P-1:0] dfl, input logic [P-1:0] rfm,
                      input bit rv, input logic [T-1:0] rt, input bit rm);
    branch_dispatch    = bd;
    dispatch_free_list = dfl;
    retire_free_mask   = rfm;
    resolve_valid      = rv;
    resolve_tag        = rt;
    resolve_mispredict = rm;
    @(posedge clock);
    model_step();
    @(negedge clock);
    $display("t=%0t bd=%0d dfl=%h rfm=%h rv=%0d rt=%0d mis=%0d -> tag=%0d cnt=%0d full=%0d rf=%0d flr=%h sq=%b",
             $time, bd, dfl, rfm, rv, rt, rm, branch_tag, num_checkpoints, stack_full,
             restore_flag, free_list_restore, squash_mask);
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    check_en = 1'b0;
    branch_dispatch = 1'b0;
    resolve_valid = 1'b0;
    resolve_mispredict = 1'b0;
    retire_free_mask = '0;
    reset = 1'b1;
    @(negedge clock);
    model_reset();
    reset = 1'b0;
    check_en = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset();

    // Reset state.
    chk("rst branch_tag", 64'(branch_tag), 64'd0);
    chk("rst stack_full", 64'(stack_full), 64'd0);
    chk("rst num_checkpoints", 64'(num_checkpoints), 64'd0);
    chk("rst restore_flag", 64'(restore_flag), 64'd0);

    // Fill to full; the fifth dispatch is dropped.
    for (int i = 0; i < 5; i++) begin
      if (i < 4) chk("fill tag", 64'(branch_tag), 64'(i));
      step(1'b1, P'(16'h0100 + i), '0, 1'b0, '0, 1'b0);
      if (i == 3) chk("fill full after 4th", 64'(stack_full), 64'd1);
    end
    chk("fill num after 5th", 64'(num_checkpoints), 64'd4);
    chk("fill tag after 5th", 64'(branch_tag), 64'd0);

    // Mispredict restore with a retire merged into the snapshot.
    do_reset();
    step(1'b1, P'(16'h0001), '0, 1'b0, '0, 1'b0);
    step(1'b1, P'(16'h000F), '0, 1'b0, '0, 1'b0);
    step(1'b1, P'(16'h0003), '0, 1'b0, '0, 1'b0);
    step(1'b1, P'(16'h0007), '0, 1'b0, '0, 1'b0);
    step(1'b0, '0, P'(16'h0030), 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b1, T'(1), 1'b1);
    chk("mp restore_flag", 64'(restore_flag), 64'd1);
    chk("mp free_list_restore", 64'(free_list_restore), 64'h3F);
    chk("mp squash_mask", 64'(squash_mask), 64'b1110);
    chk("mp tail", 64'(branch_tag), 64'd1);
    idle();
    chk("mp pulse ends", 64'(restore_flag), 64'd0);

    // Out-of-order correct resolves; head walks over freed slots one per cycle.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, P'(i), '0, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b1, T'(1), 1'b0);
    chk("ooo head held", 64'(num_checkpoints), 64'd3);
    step(1'b0, '0, '0, 1'b1, T'(0), 1'b0);
    chk("ooo before walk", 64'(num_checkpoints), 64'd3);
    idle();
    chk("ooo walk 1", 64'(num_checkpoints), 64'd2);
    idle();
    chk("ooo walk 2", 64'(num_checkpoints), 64'd1);

    // Wrap-around: churn head/tail to 3, then fill across the wrap.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, P'(i), '0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, T'(i), 1'b0);
    for (int i = 0; i < 4; i++) idle();
    chk("wrap empty", 64'(num_checkpoints), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("wrap tag", 64'(branch_tag), 64'((3 + i) % 4));
      step(1'b1, P'(16'h1000 + i), '0, 1'b0, '0, 1'b0);
    end
    step(1'b0, '0, '0, 1'b1, T'(0), 1'b1);
    chk("wrap squash_mask", 64'(squash_mask), 64'b0111);
    chk("wrap tail", 64'(branch_tag), 64'd0);
    chk("wrap num", 64'(num_checkpoints), 64'd1);

    // Dispatch and mispredict together: mispredict wins.
    do_reset();
    step(1'b1, P'(16'h00AA), '0, 1'b0, '0, 1'b0);
    step(1'b1, P'(16'h00BB), '0, 1'b1, T'(0), 1'b1);
    chk("sim num", 64'(num_checkpoints), 64'd0);
    chk("sim restore_flag", 64'(restore_flag), 64'd1);
    chk("sim free_list_restore", 64'(free_list_restore), 64'h00AA);
    idle();
    chk("sim pulse once", 64'(restore_flag), 64'd0);

    // Asynchronous reset between edges while a restore is showing.
    do_reset();
    step(1'b1, P'(16'h0055), '0, 1'b0, '0, 1'b0);
    step(1'b1, '0, '0, 1'b1, T'(0), 1'b1);
    chk("arst pending", 64'(restore_flag), 64'd1);
    check_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst restore_flag", 64'(restore_flag), 64'd0);
    chk("arst free_list_restore", 64'(free_list_restore), 64'd0);
    chk("arst squash_mask", 64'(squash_mask), 64'd0);
    chk("arst branch_tag", 64'(branch_tag), 64'd0);
    chk("arst stack_full", 64'(stack_full), 64'd0);
    chk("arst num", 64'(num_checkpoints), 64'd0);
    @(negedge clock);
    model_reset();
    reset = 1'b0;
    check_en = 1'b1;

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      step(bit'($urandom_range(0, 1)),
           P'($urandom),
           P'($urandom & $urandom & $urandom),
           bit'($urandom_range(0, 1)),
           T'($urandom_range(0, D - 1)),
           ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fl_checkpoint_ctrl.md
FL_CHECKPOINT_CTRL -- requirements
Module: fl_checkpoint_ctrl

Interface
REQ-001 Parameter BRANCH_DEPTH, default 4: number of free-list checkpoint slots; power of two, at least 2.
REQ-002 Parameter PHYS_REG_SZ, default `PHYS_REG_SZ_R10K: width of the free-list bit vectors.
REQ-003 Parameter TAG_BITS, default $clog2(BRANCH_DEPTH): width of a checkpoint tag.
REQ-004 clock  in  1  sole clock; all state updates on posedge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 branch_dispatch  in  1  a branch is dispatching this cycle and requests a checkpoint.
REQ-007 dispatch_free_list  in  PHYS_REG_SZ  free list as it stands after this cycle's dispatch; this is the value to snapshot.
REQ-008 retire_free_mask  in  PHYS_REG_SZ  one-hot-per-register mask of phys regs freed by retire this cycle.
REQ-009 resolve_valid  in  1  a branch resolves this cycle.
REQ-010 resolve_tag  in  TAG_BITS  checkpoint tag of the resolving branch.
REQ-011 resolve_mispredict  in  1  qualifies resolve_valid: the branch mispredicted.
REQ-012 branch_tag  out  TAG_BITS  tag assigned to a dispatching branch; equals the tail pointer (combinational).
REQ-013 stack_full  out  1  count == BRANCH_DEPTH (combinational).
REQ-014 num_checkpoints  out  TAG_BITS+1  occupied slots, tail minus head (combinational).
REQ-015 restore_flag  out  1  registered one-cycle pulse that triggers a free-list restore.
REQ-016 free_list_restore  out  PHYS_REG_SZ  registered free list to restore; valid only while restore_flag = 1.
REQ-017 squash_mask  out  BRANCH_DEPTH  registered mask of squashed slots; valid only while restore_flag = 1.

Function
REQ-018 State: circular slot array {valid, snapshot}; head and tail pointers of TAG_BITS+1 bits, where the MSB is a wrap bit; count = tail - head.
REQ-019 Allocate: when branch_dispatch = 1, stack_full = 0, and no mispredict occurs this cycle, the block writes slot[tail] = {1, dispatch_free_list | retire_free_mask} and increments tail.
REQ-020 Dispatch while full: ignored; no state changes. The upstream stall is the dispatcher's responsibility.
REQ-021 Retire merge: every cycle, each valid slot not being freed this cycle ORs retire_free_mask into its snapshot.
REQ-022 Correct resolve: when resolve_valid = 1, resolve_mispredict = 0, and slot[resolve_tag] is valid, the block clears that slot's valid bit.
REQ-023 Head retirement: the block advances head past at most one invalid slot per cycle, while count > 0 and slot[head] is invalid.
REQ-024 Mispredict on valid slot m, same cycle:
  - clear valid on slot m and all younger slots;
  - set tail = m's index;
  - if m is the oldest slot, set head = tail; otherwise head is unchanged.
REQ-025 Mispredict outputs, next cycle:
  - restore_flag = 1;
  - free_list_restore = slot[m].snapshot | retire_free_mask from the mispredict cycle;
  - squash_mask bit set for m and every slot younger than m (wrap-aware);
  - all three outputs return to 0 the cycle after.
REQ-026 Resolve to an invalid slot: ignored; restore_flag stays 0.
REQ-027 Mispredict and dispatch in the same cycle: mispredict wins; no allocation occurs.
REQ-028 Wrap-around: pointers wrap modulo BRANCH_DEPTH in the index bits and toggle the wrap bit; full and empty are distinguished by the wrap bit.
REQ-029 Latency:
  - allocation is visible in num_checkpoints the next cycle;
  - restore outputs appear exactly one cycle after the mispredict.

Reset
REQ-030 On reset assertion the block immediately clears head, tail, all valid bits, restore_flag, free_list_restore, and squash_mask.
REQ-031 Resulting outputs: branch_tag = 0, stack_full = 0, num_checkpoints = 0.
REQ-032 Reset asserted mid-restore cancels any pending restore_flag pulse.

Verification
REQ-033 Fill/full: dispatch 5 branches on consecutive cycles with DEPTH = 4 -> tags 0, 1, 2, 3 assigned; stack_full = 1 after the 4th; the 5th is ignored; num_checkpoints = 4.
REQ-034 Mispredict restore: snapshot 0x0F at tag 1, then retire_free_mask 0x30, then mispredict tag 1 -> next cycle restore_flag = 1, free_list_restore = 0x3F, squash_mask = 4'b1110 (tags 1-3 valid), tail = 1.
REQ-035 Out-of-order resolve: tags 0-2 live; correct-resolve tag 1 -> head stays 0; correct-resolve tag 0 -> head advances to 2 over two cycles; num_checkpoints reaches 1.
REQ-036 Wrap: with head = 3 and tail = 3 after churn, dispatch 4 branches -> tags 3, 0, 1, 2; mispredict tag 0 -> squash_mask = 4'b0111, tail = 0.
REQ-037 Simultaneous: dispatch and mispredict of tag 0 in the same cycle -> no allocation; num_checkpoints = 0; restore_flag pulses once.
REQ-038 Async reset mid-operation: reset asserted between clock edges while restore is pending -> all outputs are 0 before the next posedge.
